lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator for the word-addressed data memory.
- Accepts one CPU load/store request at a time (RV32I funct3 encodings) and turns it into memory-side address, byte-lane write enables and lane-aligned write data.
- Extracts and sign- or zero-extends load data from the memory's combinational read port.
- Returns a one-cycle response carrying the data or an error flag.

Parameters:
MEM_WORDS, 201, number of 32-bit words in the data memory; word index = addr[11:2]; index >= MEM_WORDS is out of range.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready at posedge.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
rsp_valid  out  1  one-cycle pulse, no backpressure.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  valid with rsp_valid; misaligned, out-of-range or illegal funct3.
mem_addr  out  32  byte address to memory.
mem_din  out  32  lane-replicated store data.
mem_we  out  4  byte-lane write enables.
mem_dout  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- States: IDLE, ACC0, ACC1, RESP.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_din=0, mem_we=0.
- IDLE:
  - On accept, latch we, funct3, addr and wdata, then check the request.
  - off = addr[1:0].
  - Error if funct3 is illegal: loads 011/110/111; stores anything other than 000/001/010.
  - Error if misaligned: H/HU with off[0]=1; W with off!=0.
  - Error if addr[11:2] >= MEM_WORDS.
  - Error → go to RESP with err=1. No memory access.
  - Otherwise → go to ACC0.
- ACC0:
  - mem_addr = {addr[31:2],2'b00}.
  - mem_we = store mask (B: 0001<<off; H: 0011<<off; W: 1111); 0000 for loads.
  - mem_din: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
  - Loads capture mem_dout at the posedge ending ACC0.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Load data = mem_dout >> (8*off), then B/H sign-extend, BU/HU zero-extend, W pass-through.
  - Go to IDLE.
- Latency: accept at edge N; ACC0 occupies cycle N+1; rsp_valid high in cycle N+2. Error requests respond in cycle N+1.
- Throughput: back-to-back requests are accepted in the cycle after RESP.
- mem_we is decoded combinationally from state and gated by !rst. It is 0000 in every state except ACC0/ACC1 of a store. rst asserted during ACC0 suppresses that write.
- rsp_rdata/rsp_err hold their last values after RESP; only rsp_valid qualifies them.
- Reset mid-operation: the next state is IDLE, the in-flight request is dropped and no response is produced.
- req inputs are ignored while req_ready=0.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined:
  - Misaligned H/HU/W requests are not errors. They are split into two word accesses.
  - ACC0: low word W0={addr[31:2],00}. ACC1: W0+4, wrapping modulo 2^32, so 0xFFFFFFFE → second word 0x00000000.
  - 64-bit lane view: wide_we = base_mask << off; wide_din = {32'b0, wdata} << (8*off).
  - ACC0 drives the low halves; ACC1 drives the high halves.
  - Loads capture both words; result = {hi,lo} >> (8*off), then extend.
  - The range check is applied to both word indices before ACC0. Either out of range → err, no write to either word.
  - Latency: rsp_valid in cycle N+3 for split requests; aligned requests are unchanged.
- Undefined: the ACC1 state is absent and misaligned requests return err as above.

Test Plan:
- Reset: hold rst 2 cycles → all outputs at reset values, req_ready=1, mem_we=0000.
- SB addr 0x0000_0013, wdata 0x1234_56A5 → ACC0 cycle: mem_addr 0x10, mem_we 1000, mem_din 0xA5A5A5A5; rsp_valid at N+2, rsp_err 0, rsp_rdata 0.
- LB then LBU at addr 0x13, mem word 0xA5000000 → rsp_rdata 0xFFFFFFA5 then 0x000000A5. LH addr 0x12 with word 0x80010000 → 0xFFFF8001.
- Errors, each responding at N+1 with rsp_err=1, mem_we never nonzero:
  - LW addr 0x0000_0006 (macro off).
  - SW addr 4*MEM_WORDS.
  - Load funct3 011.
- MISALIGN_SPLIT_EN: SW 0xDDCCBBAA to addr 0x0000_0007 → ACC0 mem_addr 0x04 we 1000; ACC1 mem_addr 0x08 we 0111; LW from same addr returns 0xDDCCBBAA at N+3.
- Assert rst during ACC0 of an SW → mem_we=0000 that cycle, memory unchanged, no rsp_valid, req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store initiator for the word-addressed data memory.
//
// Takes one CPU load/store request at a time (RV32I funct3 encodings), checks
// it, drives the memory with a word address, byte-lane write enables and
// lane-aligned write data, then returns a one-cycle response with the
// extended load data or an error flag.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only while the controller is
// idle, so request inputs are ignored at every other time. rsp_valid is a
// one-cycle pulse with no backpressure; rsp_rdata/rsp_err are meaningful
// only while rsp_valid is high and otherwise hold their last value.
//
// Build option:
//   MISALIGN_SPLIT_EN  when defined, misaligned H/HU/W requests are split into
//                      two word accesses (ACC0 low word, ACC1 next word)
//                      instead of returning an error.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_funct3         000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr           byte address
//   req_wdata          store data, right-justified
//   rsp_valid          one-cycle response strobe
//   rsp_rdata          extended load data (0 for stores and errors)
//   rsp_err            illegal funct3, misaligned or out-of-range request
//   mem_addr           word-aligned byte address to memory
//   mem_din            lane-placed store data
//   mem_we             byte-lane write enables
//   mem_dout           memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int MEM_WORDS = 201
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_dout
);

   localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

`ifdef MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      RESP = 2'd3
   } state_t;
`endif

   state_t      state;

   // Latched request attributes used after acceptance.
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
`ifdef MISALIGN_SPLIT_EN
   logic        split_q;
   logic [31:0] wdata_q;
   logic [31:0] lo_q;      // low word of a split load, captured in ACC0
`endif

   // ------------------------------------------------------------------------
   // Request check, evaluated on the raw request inputs while idle.
   // ------------------------------------------------------------------------
   logic        f3_ok;
   logic        mis;
   logic        idx0_bad;
   logic        req_err;
   logic [9:0]  idx0;
   logic [31:0] rep_din;
   logic [31:0] acc0_din;

   assign idx0     = req_addr[11:2];
   assign idx0_bad = {22'd0, idx0} >= MEM_WORDS_U;

   always_comb begin
      f3_ok = 1'b0;
      mis   = 1'b0;
      case (req_funct3)
         3'b000: f3_ok = 1'b1;
         3'b001: begin
            f3_ok = 1'b1;
            mis   = req_addr[0];
         end
         3'b010: begin
            f3_ok = 1'b1;
            mis   = |req_addr[1:0];
         end
         // Unsigned variants exist only for loads.
         3'b100: f3_ok = !req_we;
         3'b101: begin
            f3_ok = !req_we;
            mis   = req_addr[0];
         end
         default: f3_ok = 1'b0;
      endcase
   end

   // Aligned store data is replicated across all lanes; the write enables
   // select the lanes that actually change.
   always_comb begin
      case (req_funct3[1:0])
         2'b00:   rep_din = {4{req_wdata[7:0]}};
         2'b01:   rep_din = {2{req_wdata[15:0]}};
         default: rep_din = req_wdata;
      endcase
   end

`ifdef MISALIGN_SPLIT_EN
   logic [9:0] idx1;
   logic       idx1_bad;
   logic       split;

   // Second word index wraps with the 32-bit address, so it wraps mod 1024.
   assign idx1     = idx0 + 10'd1;
   assign idx1_bad = {22'd0, idx1} >= MEM_WORDS_U;
   assign split    = f3_ok & mis;
   assign req_err  = !f3_ok | idx0_bad | (split & idx1_bad);
   // Split stores use the shifted 64-bit lane view; its low half goes first.
   assign acc0_din = split ? (req_wdata << {req_addr[1:0], 3'b000}) : rep_din;
`else
   assign req_err  = !f3_ok | mis | idx0_bad;
   assign acc0_din = rep_din;
`endif

   // ------------------------------------------------------------------------
   // Lane enables derived from the latched request.
   // ------------------------------------------------------------------------
   logic [3:0] base_we;
   logic [3:0] lo_we;

   always_comb begin
      case (f3_q[1:0])
         2'b00:   base_we = 4'b0001;
         2'b01:   base_we = 4'b0011;
         default: base_we = 4'b1111;
      endcase
   end

   assign lo_we = base_we << off_q;

`ifdef MISALIGN_SPLIT_EN
   logic [3:0]  hi_we;
   logic [31:0] hi_din;

   // Upper halves of the 64-bit lane view, driven during ACC1.
   assign hi_we  = 4'(({4'd0, base_we} << off_q) >> 4);
   assign hi_din = 32'(({32'd0, wdata_q} << {off_q, 3'b000}) >> 32);
`endif

   // Write enables are combinational so that a reset asserted during an
   // access cycle suppresses that cycle's write.
   always_comb begin
      mem_we = 4'b0000;
      if (!rst && we_q) begin
         if (state == ACC0) begin
            mem_we = lo_we;
         end
`ifdef MISALIGN_SPLIT_EN
         else if (state == ACC1) begin
            mem_we = hi_we;
         end
`endif
      end
   end

   // Shift the (up to) two-word read window down to the addressed byte and
   // apply the sign/zero extension selected by funct3.
   function automatic logic [31:0] extend(input logic [63:0] pair,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
      logic [31:0] sh;
      sh = 32'(pair >> {off, 3'b000});
      case (f3)
         3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
         3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
         3'b100:  extend = {24'd0, sh[7:0]};
         3'b101:  extend = {16'd0, sh[15:0]};
         default: extend = sh;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         mem_addr  <= 32'd0;
         mem_din   <= 32'd0;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
`ifdef MISALIGN_SPLIT_EN
         split_q   <= 1'b0;
         wdata_q   <= 32'd0;
         lo_q      <= 32'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (req_valid) begin
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  off_q     <= req_addr[1:0];
                  req_ready <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
                  wdata_q   <= req_wdata;
                  split_q   <= split;
`endif
                  if (req_err) begin
                     // Rejected requests never touch memory.
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'd0;
                  end else begin
                     state     <= ACC0;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_din   <= acc0_din;
                  end
               end
            end

            ACC0: begin
`ifdef MISALIGN_SPLIT_EN
               if (split_q) begin
                  lo_q     <= mem_dout;
                  mem_addr <= mem_addr + 32'd4;
                  mem_din  <= hi_din;
                  state    <= ACC1;
               end else
`endif
               begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= we_q ? 32'd0 : extend({32'd0, mem_dout}, off_q, f3_q);
                  state     <= RESP;
               end
            end

`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= we_q ? 32'd0 : extend({mem_dout, lo_q}, off_q, f3_q);
               state     <= RESP;
            end
`endif

            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// A byte-level reference model predicts, per request, the cycle-by-cycle
// handshake, memory accesses and response; one compare process checks the
// DUT against those predictions on every cycle. Directed cases pin the model
// with hand-computed literals. Honours MISALIGN_SPLIT_EN like the design.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;
  localparam int MEM_WORDS = 201;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0] mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // ---------------- data memory attached to the DUT ----------------
  logic [31:0] mem_arr [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic mem_clr;
  logic [9:0] m_idx;
  assign m_idx = mem_addr[11:2];
  assign mem_dout = (int'(m_idx) < MEM_WORDS) ? mem_arr[m_idx] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] <= 32'h0;
    end else if (int'(m_idx) < MEM_WORDS) begin
      for (int j = 0; j < 4; j++)
        if (mem_we[j]) mem_arr[m_idx][8*j +: 8] <= mem_din[8*j +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic chk_en = 1'b0;
  logic exp_ready, exp_rv, exp_err, exp_acc;
  logic [31:0] exp_rdata, exp_maddr, exp_din;
  logic [3:0] exp_we, exp_dmask;

  task automatic set_exp(input logic ready, input logic rv, input logic err,
                         input logic [31:0] rdata, input logic [3:0] we,
                         input logic acc, input logic [31:0] maddr,
                         input logic [31:0] din, input logic [3:0] dmask);
    exp_ready = ready; exp_rv = rv; exp_err = err; exp_rdata = rdata;
    exp_we = we; exp_acc = acc; exp_maddr = maddr; exp_din = din; exp_dmask = dmask;
  endtask

  // single compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      chk("mem_we", {28'd0, mem_we}, {28'd0, exp_we});
      if (exp_rv) begin
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
      if (exp_acc) begin
        logic [31:0] g, e;
        chk("mem_addr", mem_addr, exp_maddr);
        g = 32'h0; e = 32'h0;
        for (int j = 0; j < 4; j++)
          if (exp_dmask[j]) begin
            g[8*j +: 8] = mem_din[8*j +: 8];
            e[8*j +: 8] = exp_din[8*j +: 8];
          end
        if (exp_dmask != 4'd0) chk("mem_din", g, e);
      end
    end
  end

  // ---------------- driver ----------------
  int got_lat;
  logic got_err;
  logic [31:0] got_rdata;
  logic [3:0] got_we [1:3];
  logic [31:0] got_addr [1:3];
  logic [31:0] got_din [1:3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_exp(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
    end
  endtask

  // Predicts the whole transaction from byte positions, then plays it out.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int size, off, i0, i1, n, pos;
    bit legal, misal, split, err;
    logic [31:0] w0, w1, val, src, lo_din, hi_din, rep;
    logic [3:0] lo_we, hi_we;
    logic [7:0] b;
    logic s_rv [1:3];
    logic s_err [1:3];
    logic s_acc [1:3];
    logic [3:0] s_we [1:3];
    logic [3:0] s_dm [1:3];
    logic [31:0] s_rd [1:3];
    logic [31:0] s_ma [1:3];
    logic [31:0] s_din [1:3];

    off = int'(addr[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = (off % size) != 0;
`ifdef MISALIGN_SPLIT_EN
    split = legal && misal;
`else
    split = 1'b0;
`endif
    w0 = {addr[31:2], 2'b00};
    w1 = w0 + 32'd4;
    i0 = int'(w0[11:2]);
    i1 = int'(w1[11:2]);
    err = !legal || (misal && !split) || (i0 >= MEM_WORDS) || (split && i1 >= MEM_WORDS);

    for (int k = 1; k <= 3; k++) begin
      s_rv[k] = 0; s_err[k] = 0; s_acc[k] = 0; s_we[k] = 0; s_dm[k] = 0;
      s_rd[k] = 0; s_ma[k] = 0; s_din[k] = 0;
    end

    if (err) begin
      n = 1;
      s_rv[1] = 1; s_err[1] = 1;
    end else begin
      lo_we = 0; hi_we = 0; lo_din = 0; hi_din = 0; val = 0;
      for (int k = 0; k < size; k++) begin
        pos = off + k;
        b = wd[8*k +: 8];
        if (pos < 4) begin
          lo_we[pos] = 1'b1; lo_din[8*pos +: 8] = b; src = ref_mem[i0];
        end else begin
          hi_we[pos-4] = 1'b1; hi_din[8*(pos-4) +: 8] = b; src = ref_mem[i1];
        end
        val[8*k +: 8] = src[8*(pos%4) +: 8];
      end
      if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
      if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
      if (we) begin
        for (int k = 0; k < size; k++) begin
          pos = off + k;
          if (pos < 4) ref_mem[i0][8*pos +: 8] = wd[8*k +: 8];
          else ref_mem[i1][8*(pos-4) +: 8] = wd[8*k +: 8];
        end
      end
      rep = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      s_acc[1] = 1; s_ma[1] = w0;
      s_we[1] = we ? lo_we : 4'h0;
      s_din[1] = split ? lo_din : rep;
      s_dm[1] = !we ? 4'h0 : (split ? lo_we : 4'hF);
      if (split) begin
        n = 3;
        s_acc[2] = 1; s_ma[2] = w1;
        s_we[2] = we ? hi_we : 4'h0;
        s_din[2] = hi_din;
        s_dm[2] = we ? hi_we : 4'h0;
      end else begin
        n = 2;
      end
      s_rv[n] = 1;
      s_rd[n] = we ? 32'h0 : val;
    end

    // accept cycle
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    got_lat = 0; got_err = 1'b0; got_rdata = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      got_we[k] = 4'h0; got_addr[k] = 32'h0; got_din[k] = 32'h0;
    end
    for (int k = 1; k <= n; k++) begin
      garbage();
      set_exp(1'b0, s_rv[k], s_err[k], s_rd[k], s_we[k], s_acc[k], s_ma[k], s_din[k], s_dm[k]);
      got_we[k] = mem_we; got_addr[k] = mem_addr; got_din[k] = mem_din;
      if (rsp_valid && got_lat == 0) begin
        got_lat = k; got_err = rsp_err; got_rdata = rsp_rdata;
      end
      step();
    end
    req_valid = 1'b0;
  endtask

  // SW accepted, then reset asserted for its ACC0 cycle.
  task automatic do_abort(input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = wd;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    rst = 1'b0;
    idle(2);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
    step();
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_en = 1'b1;
    idle(2);

    // SB 0x13 -> word 4 becomes 0xA5000000
    do_req(1'b1, 3'b000, 32'h0000_0013, 32'h1234_56A5);
    chk("sb_addr", got_addr[1], 32'h0000_0010);
    chk("sb_we", {28'd0, got_we[1]}, 32'h8);
    chk("sb_din", got_din[1], 32'hA5A5_A5A5);
    chk("sb_lat", got_lat, 32'd2);
    chk("sb_err", {31'd0, got_err}, 32'd0);
    chk("sb_rdata", got_rdata, 32'h0);

    do_req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    chk("lb_rdata", got_rdata, 32'hFFFF_FFA5);
    chk("lb_lat", got_lat, 32'd2);
    do_req(1'b0, 3'b100, 32'h0000_0013, 32'h0);
    chk("lbu_rdata", got_rdata, 32'h0000_00A5);

    do_req(1'b1, 3'b010, 32'h0000_0010, 32'h8001_0000);
    do_req(1'b0, 3'b001, 32'h0000_0012, 32'h0);
    chk("lh_rdata", got_rdata, 32'hFFFF_8001);

    // error requests
`ifndef MISALIGN_SPLIT_EN
    do_req(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    chk("lw_mis_err", {31'd0, got_err}, 32'd1);
    chk("lw_mis_lat", got_lat, 32'd1);
`endif
    do_req(1'b1, 3'b010, 32'(4 * MEM_WORDS), 32'hCAFE_F00D);
    chk("sw_range_err", {31'd0, got_err}, 32'd1);
    chk("sw_range_lat", got_lat, 32'd1);
    chk("sw_range_we", {28'd0, got_we[1]}, 32'd0);
    do_req(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    chk("ld_f3_err", {31'd0, got_err}, 32'd1);

`ifdef MISALIGN_SPLIT_EN
    do_req(1'b1, 3'b010, 32'h0000_0007, 32'hDDCC_BBAA);
    chk("split_addr0", got_addr[1], 32'h0000_0004);
    chk("split_we0", {28'd0, got_we[1]}, 32'h8);
    chk("split_addr1", got_addr[2], 32'h0000_0008);
    chk("split_we1", {28'd0, got_we[2]}, 32'h7);
    do_req(1'b0, 3'b010, 32'h0000_0007, 32'h0);
    chk("split_lw", got_rdata, 32'hDDCC_BBAA);
    chk("split_lat", got_lat, 32'd3);
`endif

    // reset during ACC0 of a store: word 4 must keep 0x80010000
    do_abort(32'h0000_0010, 32'h1111_2222);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    chk("abort_keep", got_rdata, 32'h8001_0000);

    // randomized traffic, back-to-back and with gaps
    for (int n = 0; n < 400; n++) begin
      int idx;
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0: idx = 1023;
        1: idx = int'($urandom_range(MEM_WORDS - 2, MEM_WORDS + 1));
        default: idx = int'($urandom_range(0, MEM_WORDS - 1));
      endcase
      a = {(($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0), 10'(idx), 2'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    for (int i = 0; i < MEM_WORDS; i++) chk("mem_word", mem_arr[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
